// File: rtl/uart_program_loader_pkg.sv
// uart_program_loader_pkg
//   Shared definitions for the boot-time program loader: the loader FSM
//   state encoding and the default halt sentinel word. Imported by the
//   loader RTL and by anything that needs to decode the loader state.
package uart_program_loader_pkg;

   typedef enum logic [1:0] {
      ST_RECV  = 2'd0,   // popping bytes from the RX FIFO
      ST_WRITE = 2'd1,   // one-cycle instruction-memory write
      ST_DONE  = 2'd2    // load finished, CPU released
   } loader_state_t;

   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_program_loader_word_assembler.sv
// word_assembler
//   4-byte shift register that builds a 32-bit word from a byte stream.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset (clears word/count)
//     push        - a byte is accepted this cycle
//     data[7:0]   - byte accepted when push=1
//     word[31:0]  - assembly register contents
//     word_ready  - combinational pulse: this push completes a word
//                   (count wraps 3 -> 0); word holds it from the next cycle
//   LITTLE_ENDIAN=0: first byte ends up in [31:24]; =1: first byte in [7:0].
module word_assembler #(
   parameter bit LITTLE_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (push) begin
         // Big-endian shifts left so the oldest byte drifts to the top;
         // little-endian shifts right so the oldest byte drifts to the bottom.
         if (LITTLE_ENDIAN)
            word <= {data, word[31:8]};
         else
            word <= {word[23:0], data};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_ready = push & (byte_cnt == 2'd3);

endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Pops bytes from a first-word-fall-through UART RX FIFO, assembles them
//   into 32-bit words and writes them to instruction memory starting at
//   word address 0, holding the CPU in reset until a halt sentinel is
//   written or the last address has been written.
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     rd_empty, r_data    - RX FIFO empty flag and head byte
//     rd                  - RX FIFO pop strobe
//     mem_we              - one-cycle instruction-memory write enable
//     mem_addr, mem_wdata - write address / word (stable while mem_we=1)
//     load_done           - sticky: loading finished
//     overflow            - sticky: loading ended on address exhaustion
//     cpu_reset           - CPU reset hold, ~load_done
//     fsm_state           - current loader state, for observation
module uart_program_loader
   import uart_program_loader_pkg::*;
#(
   parameter int          ADDR_WIDTH    = 8,
   parameter bit          LITTLE_ENDIAN = 1'b0,
   parameter logic [31:0] HALT_WORD     = DEFAULT_HALT_WORD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_empty,
   input  logic [7:0]            r_data,
   output logic                  rd,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  load_done,
   output logic                  overflow,
   output logic                  cpu_reset,
   output loader_state_t         fsm_state
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   loader_state_t state, state_next;
   logic [31:0]   word;
   logic          word_ready;

   // FIFO handshake: the head byte is valid whenever rd_empty=0; the loader
   // is ready only in RECV and out of reset. A byte transfers (and is
   // consumed by the FIFO) in exactly the cycles where rd=1.
   assign rd = (state == ST_RECV) & ~rd_empty & ~reset;

   word_assembler #(
      .LITTLE_ENDIAN (LITTLE_ENDIAN)
   ) u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .push       (rd),
      .data       (r_data),
      .word       (word),
      .word_ready (word_ready)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_RECV: begin
            if (word_ready)
               state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if ((word == HALT_WORD) || (mem_addr == ADDR_LAST))
               state_next = ST_DONE;
            else
               state_next = ST_RECV;
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_RECV;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RECV;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         overflow <= 1'b0;
      end else begin
         state  <= state_next;
         // Registered strobe: high exactly while the FSM sits in WRITE.
         mem_we <= (state_next == ST_WRITE);
         if ((state == ST_WRITE) && (state_next == ST_RECV))
            mem_addr <= mem_addr + 1'b1;
         // Leaving WRITE for DONE without the sentinel means the address
         // space ran out; the sentinel wins if both happen together.
         if ((state == ST_WRITE) && (state_next == ST_DONE) && (word != HALT_WORD))
            overflow <= 1'b1;
      end
   end

   // The assembly register cannot change during WRITE (no pop), so it
   // serves directly as the registered write data.
   assign mem_wdata = word;
   assign load_done = (state == ST_DONE);
   assign cpu_reset = ~load_done;
   assign fsm_state = state;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//   Three loader instances: u0 default (8-bit address, big-endian),
//   u1 with a 2-bit address space, u2 little-endian. Each is fed by a
//   queue-based FIFO model; writes are captured and compared with a
//   byte-stream reference model.
module tb_uart_program_loader;
   import uart_program_loader_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   int   cyc = 0;

   // ---------------- DUT signals ----------------
   logic          rd_empty0, rd_empty1, rd_empty2;
   logic [7:0]    r_data0, r_data1, r_data2;
   logic          rd0, rd1, rd2;
   logic          mem_we0, mem_we1, mem_we2;
   logic [7:0]    mem_addr0, mem_addr2;
   logic [1:0]    mem_addr1;
   logic [31:0]   mem_wdata0, mem_wdata1, mem_wdata2;
   logic          load_done0, load_done1, load_done2;
   logic          overflow0, overflow1, overflow2;
   logic          cpu_reset0, cpu_reset1, cpu_reset2;
   loader_state_t fsm_state0, fsm_state1, fsm_state2;

   uart_program_loader u0 (
      .clk(clk), .reset(reset), .rd_empty(rd_empty0), .r_data(r_data0), .rd(rd0),
      .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .load_done(load_done0), .overflow(overflow0), .cpu_reset(cpu_reset0),
      .fsm_state(fsm_state0));

   uart_program_loader #(.ADDR_WIDTH(2)) u1 (
      .clk(clk), .reset(reset), .rd_empty(rd_empty1), .r_data(r_data1), .rd(rd1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .load_done(load_done1), .overflow(overflow1), .cpu_reset(cpu_reset1),
      .fsm_state(fsm_state1));

   uart_program_loader #(.LITTLE_ENDIAN(1'b1)) u2 (
      .clk(clk), .reset(reset), .rd_empty(rd_empty2), .r_data(r_data2), .rd(rd2),
      .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .load_done(load_done2), .overflow(overflow2), .cpu_reset(cpu_reset2),
      .fsm_state(fsm_state2));

   // ---------------- FIFO models ----------------
   logic [7:0] fifo0[$], fifo1[$], fifo2[$];

   task automatic refresh();
      rd_empty0 = (fifo0.size() == 0);
      rd_empty1 = (fifo1.size() == 0);
      rd_empty2 = (fifo2.size() == 0);
      r_data0   = (fifo0.size() != 0) ? fifo0[0] : 8'h00;
      r_data1   = (fifo1.size() != 0) ? fifo1[0] : 8'h00;
      r_data2   = (fifo2.size() != 0) ? fifo2[0] : 8'h00;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rd0 && fifo0.size() != 0) void'(fifo0.pop_front());
      if (rd1 && fifo1.size() != 0) void'(fifo1.pop_front());
      if (rd2 && fifo2.size() != 0) void'(fifo2.pop_front());
      #1;
      refresh();
   end

   // ---------------- monitors ----------------
   logic [39:0] obs0[$], obs1[$], obs2[$];
   int          we_cyc0[$];
   int          pops0, pops1, pops2;
   int          viol0, viol1, viol2;

   always @(negedge clk) begin
      if (mem_we0) begin
         obs0.push_back({mem_addr0, mem_wdata0});
         we_cyc0.push_back(cyc);
         if (rd0) viol0++;
      end
      if (mem_we1) begin
         obs1.push_back({6'b0, mem_addr1, mem_wdata1});
         if (rd1) viol1++;
      end
      if (mem_we2) begin
         obs2.push_back({mem_addr2, mem_wdata2});
         if (rd2) viol2++;
      end
      if (rd0) pops0++;
      if (rd1) pops1++;
      if (rd2) pops2++;
   end

   // ---------------- scoreboard / reference model ----------------
   logic [39:0] exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   // Groups the byte stream into words, numbers them from address 0 and
   // stops after the sentinel or after the last address of a 2^aw space.
   task automatic model_load(input logic [7:0] b[$], input int aw, input bit le,
                             output int n_pop, output bit done, output bit ovf);
      logic [31:0] w;
      int          addr;
      exp_q.delete();
      done = 1'b0;
      ovf  = 1'b0;
      addr = 0;
      for (int i = 0; i + 3 < b.size(); i += 4) begin
         w = le ? {b[i+3], b[i+2], b[i+1], b[i]} : {b[i], b[i+1], b[i+2], b[i+3]};
         exp_q.push_back({addr[7:0], w});
         if (w == 32'hFFFF_FFFF) begin
            done = 1'b1;
            break;
         end
         if (addr == (1 << aw) - 1) begin
            done = 1'b1;
            ovf  = 1'b1;
            break;
         end
         addr++;
      end
      n_pop = done ? 4 * exp_q.size() : b.size();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      do w = $urandom(); while (w == 32'hFFFF_FFFF);
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      fifo0.delete();
      fifo1.delete();
      fifo2.delete();
      refresh();
      @(posedge clk);
      #2;
      reset = 1'b0;
      obs0.delete(); obs1.delete(); obs2.delete(); we_cyc0.delete();
      pops0 = 0; pops1 = 0; pops2 = 0;
      viol0 = 0; viol1 = 0; viol2 = 0;
   endtask

   task automatic push_byte(input int inst, input logic [7:0] v);
      case (inst)
         0:       fifo0.push_back(v);
         1:       fifo1.push_back(v);
         default: fifo2.push_back(v);
      endcase
      refresh();
   endtask

   task automatic feed(input int inst, input logic [7:0] b[$], input int gmin, input int gmax);
      for (int i = 0; i < b.size(); i++) begin
         push_byte(inst, b[i]);
         wait_cycles($urandom_range(gmax, gmin));
      end
   endtask

   task automatic push_word_bytes(inout logic [7:0] b[$], input logic [31:0] w);
      b.push_back(w[31:24]);
      b.push_back(w[23:16]);
      b.push_back(w[15:8]);
      b.push_back(w[7:0]);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      refresh();
      push_byte(0, 8'h5A);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (rd0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b expected 0", rd0); end
      n_cmp++; if (mem_we0 !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b expected 0", mem_we0); end
      n_cmp++; if (mem_addr0 !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr got %h expected 00", mem_addr0); end
      n_cmp++; if (load_done0 !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b expected 0", load_done0); end
      n_cmp++; if (overflow0 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b expected 0", overflow0); end
      n_cmp++; if (cpu_reset0 !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset got %b expected 1", cpu_reset0); end
      n_cmp++; if (fsm_state0 !== ST_RECV) begin n_fail++; $display("FAIL reset_state got %0d expected %0d", fsm_state0, ST_RECV); end
   endtask

   task automatic test_single_word(input string name, input int gmin, input int gmax);
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      b = '{8'h12, 8'h34, 8'h56, 8'h78};
      model_load(b, 8, 1'b0, np, dn, ov);
      feed(0, b, gmin, gmax);
      wait_cycles(12);
      n_cmp++; if (obs0.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_count got %0d expected %0d", name, obs0.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs0.size(); i++) begin
         n_cmp++; if (obs0[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_write[%0d] got %h expected %h", name, i, obs0[i], exp_q[i]); end
      end
      n_cmp++; if (pops0 != np) begin n_fail++; $display("FAIL %s_pops got %0d expected %0d", name, pops0, np); end
      n_cmp++; if (viol0 != 0) begin n_fail++; $display("FAIL %s_rd_in_write got %0d expected 0", name, viol0); end
      n_cmp++; if (load_done0 !== 1'b0) begin n_fail++; $display("FAIL %s_load_done got %b expected 0", name, load_done0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      push_word_bytes(b, rand_word());
      push_word_bytes(b, rand_word());
      model_load(b, 8, 1'b0, np, dn, ov);
      feed(0, b, 0, 0);
      wait_cycles(16);
      n_cmp++; if (obs0.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d expected %0d", obs0.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs0.size(); i++) begin
         n_cmp++; if (obs0[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write[%0d] got %h expected %h", i, obs0[i], exp_q[i]); end
      end
      if (we_cyc0.size() == 2) begin
         n_cmp++; if (we_cyc0[1] - we_cyc0[0] != 5) begin n_fail++; $display("FAIL b2b_spacing got %0d expected 5", we_cyc0[1] - we_cyc0[0]); end
      end else begin
         n_cmp++; n_fail++; $display("FAIL b2b_we_pulses got %0d expected 2", we_cyc0.size());
      end
      n_cmp++; if (viol0 != 0) begin n_fail++; $display("FAIL b2b_rd_in_write got %0d expected 0", viol0); end
   endtask

   task automatic test_random_stream();
      logic [7:0] b[$];
      int np; bit dn, ov;
      int n_part;
      do_reset();
      for (int k = 0; k < 5; k++) push_word_bytes(b, rand_word());
      n_part = $urandom_range(3, 1);
      for (int k = 0; k < n_part; k++) b.push_back(8'($urandom_range(255, 0)));
      model_load(b, 8, 1'b0, np, dn, ov);
      feed(0, b, 0, 2);
      wait_cycles(20);
      n_cmp++; if (obs0.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_count got %0d expected %0d", obs0.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs0.size(); i++) begin
         n_cmp++; if (obs0[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream_write[%0d] got %h expected %h", i, obs0[i], exp_q[i]); end
      end
      n_cmp++; if (pops0 != np) begin n_fail++; $display("FAIL stream_pops got %0d expected %0d", pops0, np); end
      n_cmp++; if (load_done0 !== dn) begin n_fail++; $display("FAIL stream_load_done got %b expected %b", load_done0, dn); end
      n_cmp++; if (viol0 != 0) begin n_fail++; $display("FAIL stream_rd_in_write got %0d expected 0", viol0); end
   endtask

   task automatic test_sentinel();
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      push_word_bytes(b, 32'h2008_0005);
      push_word_bytes(b, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) b.push_back(8'($urandom_range(255, 0)));
      model_load(b, 8, 1'b0, np, dn, ov);
      feed(0, b, 0, 1);
      wait_cycles(20);
      n_cmp++; if (obs0.size() != exp_q.size()) begin n_fail++; $display("FAIL sentinel_count got %0d expected %0d", obs0.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs0.size(); i++) begin
         n_cmp++; if (obs0[i] !== exp_q[i]) begin n_fail++; $display("FAIL sentinel_write[%0d] got %h expected %h", i, obs0[i], exp_q[i]); end
      end
      n_cmp++; if (load_done0 !== dn) begin n_fail++; $display("FAIL sentinel_load_done got %b expected %b", load_done0, dn); end
      n_cmp++; if (cpu_reset0 !== ~dn) begin n_fail++; $display("FAIL sentinel_cpu_reset got %b expected %b", cpu_reset0, ~dn); end
      n_cmp++; if (overflow0 !== ov) begin n_fail++; $display("FAIL sentinel_overflow got %b expected %b", overflow0, ov); end
      n_cmp++; if (fsm_state0 !== ST_DONE) begin n_fail++; $display("FAIL sentinel_state got %0d expected %0d", fsm_state0, ST_DONE); end
      n_cmp++; if (pops0 != np) begin n_fail++; $display("FAIL sentinel_pops got %0d expected %0d", pops0, np); end
      n_cmp++; if (fifo0.size() != b.size() - np) begin n_fail++; $display("FAIL sentinel_left_in_fifo got %0d expected %0d", fifo0.size(), b.size() - np); end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      b = '{8'hAA, 8'hBB};
      feed(0, b, 0, 0);
      wait_cycles(4);
      do_reset();
      b = '{8'h11, 8'h22, 8'h33, 8'h44};
      model_load(b, 8, 1'b0, np, dn, ov);
      feed(0, b, 0, 0);
      wait_cycles(10);
      n_cmp++; if (obs0.size() != exp_q.size()) begin n_fail++; $display("FAIL midreset_count got %0d expected %0d", obs0.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs0.size(); i++) begin
         n_cmp++; if (obs0[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_write[%0d] got %h expected %h", i, obs0[i], exp_q[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      for (int k = 0; k < 4; k++) push_word_bytes(b, rand_word());
      b.push_back(8'($urandom_range(255, 0)));
      model_load(b, 2, 1'b0, np, dn, ov);
      feed(1, b, 0, 1);
      wait_cycles(30);
      n_cmp++; if (obs1.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got %0d expected %0d", obs1.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs1.size(); i++) begin
         n_cmp++; if (obs1[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_write[%0d] got %h expected %h", i, obs1[i], exp_q[i]); end
      end
      n_cmp++; if (overflow1 !== ov) begin n_fail++; $display("FAIL ovf_overflow got %b expected %b", overflow1, ov); end
      n_cmp++; if (load_done1 !== dn) begin n_fail++; $display("FAIL ovf_load_done got %b expected %b", load_done1, dn); end
      n_cmp++; if (cpu_reset1 !== ~dn) begin n_fail++; $display("FAIL ovf_cpu_reset got %b expected %b", cpu_reset1, ~dn); end
      n_cmp++; if (fifo1.size() != b.size() - np) begin n_fail++; $display("FAIL ovf_left_in_fifo got %0d expected %0d", fifo1.size(), b.size() - np); end
      n_cmp++; if (viol1 != 0) begin n_fail++; $display("FAIL ovf_rd_in_write got %0d expected 0", viol1); end
   endtask

   task automatic test_little_endian();
      logic [7:0] b[$];
      int np; bit dn, ov;
      do_reset();
      b = '{8'h78, 8'h56, 8'h34, 8'h12};
      push_word_bytes(b, rand_word());
      push_word_bytes(b, rand_word());
      push_word_bytes(b, 32'hFFFF_FFFF);
      b.push_back(8'h9C);
      model_load(b, 8, 1'b1, np, dn, ov);
      feed(2, b, 0, 2);
      wait_cycles(24);
      n_cmp++; if (obs2.size() != exp_q.size()) begin n_fail++; $display("FAIL le_count got %0d expected %0d", obs2.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs2.size(); i++) begin
         n_cmp++; if (obs2[i] !== exp_q[i]) begin n_fail++; $display("FAIL le_write[%0d] got %h expected %h", i, obs2[i], exp_q[i]); end
      end
      n_cmp++; if (load_done2 !== dn) begin n_fail++; $display("FAIL le_load_done got %b expected %b", load_done2, dn); end
      n_cmp++; if (overflow2 !== ov) begin n_fail++; $display("FAIL le_overflow got %b expected %b", overflow2, ov); end
      n_cmp++; if (fifo2.size() != b.size() - np) begin n_fail++; $display("FAIL le_left_in_fifo got %0d expected %0d", fifo2.size(), b.size() - np); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      pops0 = 0; pops1 = 0; pops2 = 0;
      viol0 = 0; viol1 = 0; viol2 = 0;
      test_reset();
      test_single_word("single", 0, 0);
      test_single_word("gaps", 3, 10);
      test_back_to_back();
      for (int r = 0; r < 4; r++) test_random_stream();
      test_sentinel();
      test_reset_mid_word();
      test_overflow();
      test_little_endian();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time program loader sitting directly downstream of the UART receive FIFO. It pops received bytes, assembles them into 32-bit instruction words, and writes them sequentially into MIPS instruction memory from word address 0. While loading, it holds the CPU in reset. A halt sentinel word or the end of the address space finishes the load.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width.
- `LITTLE_ENDIAN`, default 0:
  - 0: the first received byte becomes bits [31:24].
  - 1: the first received byte becomes bits [7:0].
- `HALT_WORD`, default 32'hFFFF_FFFF: sentinel word that terminates loading.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `rd_empty` in 1: UART RX FIFO empty flag.
- `r_data` in 8: RX FIFO head byte. It is first-word-fall-through and valid whenever `rd_empty`=0.
- `rd` out 1: RX FIFO pop strobe. The byte on `r_data` is consumed in the same cycle.
- `mem_we` out 1: instruction-memory write enable, a one-cycle pulse.
- `mem_addr` out ADDR_WIDTH: word address of the write.
- `mem_wdata` out 32: assembled instruction word.
- `load_done` out 1: load finished. Sticky until `reset`.
- `overflow` out 1: load ended because the address space was exhausted, not because of the sentinel. Sticky.
- `cpu_reset` out 1: hold the CPU in reset. Equals ~`load_done`.

## Operation
States: RECV, WRITE, DONE. After reset the state is RECV.

RECV:
- `rd` = ~`rd_empty` & ~`reset`. The block pops every available byte.
- On each pop, the byte is shifted into the 32-bit assembly register in the order set by `LITTLE_ENDIAN`, and `byte_cnt` (2 bits) increments.
- On the pop that takes `byte_cnt` from 3 to 0, the state goes to WRITE.

WRITE (exactly one cycle):
- `mem_we`=1, `mem_addr` = current address, `mem_wdata` = assembled word.
- `rd`=0. No pop occurs in this cycle.
- Next state:
  - assembled word == `HALT_WORD` → DONE. The halt word is still written.
  - else if `mem_addr` == 2^ADDR_WIDTH−1 → DONE with `overflow` set.
  - else → RECV with `mem_addr` incremented.

DONE:
- `load_done`=1, `cpu_reset`=0, `rd`=0, `mem_we`=0.
- Bytes arriving after DONE are left in the FIFO.

Arithmetic and buffering:
- `mem_addr` never wraps. The write to the last address is the final write.
- Partial words (fewer than 4 bytes) are never written. They are held until completed or until reset.

## Timing
Reset values (same edge):
- State RECV, `byte_cnt`=0, assembly register 0, `mem_addr`=0.
- `mem_we`=0, `load_done`=0, `overflow`=0, `cpu_reset`=1.
- `rd` is forced to 0 combinationally while `reset`=1.

Latency and throughput:
- If the 4th byte is popped in cycle t, `mem_we` is high in cycle t+1, and the next pop can occur no earlier than t+2.
- Maximum throughput is 4 bytes per 5 cycles.

Output behaviour:
- `mem_we`, `mem_addr` and `mem_wdata` are registered.
- `mem_wdata` and `mem_addr` are stable for the whole cycle in which `mem_we`=1.
- `load_done` and `cpu_reset` change in the cycle after the final WRITE cycle.

Boundary conditions:
- `rd_empty`=1 in RECV: no pop, and all state is held indefinitely.
- Reset mid-word or mid-load: partial bytes are discarded and the address returns to 0. There is no memory write in the reset cycle.
- Reset during WRITE: the write is suppressed (`mem_we` registered to 0).

## Structure
- Shared package/header: state encoding (RECV, WRITE, DONE) and the default `HALT_WORD` constant. The MIPS top-level and the loader testbench both use these.
- One natural sub-module, `word_assembler`: a 4-byte shift register with `byte_cnt` and the `LITTLE_ENDIAN` ordering. It outputs the word plus a `word_ready` pulse.
- The FSM and address counter stay in `uart_program_loader`.

## Test plan
- Single word, big-endian: bytes 12,34,56,78 back-to-back → one `mem_we` at addr 0 with data 32'h12345678, `rd` low during WRITE.
- Sentinel: words 32'h20080005 then FF,FF,FF,FF → writes at addr 0 and 1 (addr 1 = 32'hFFFFFFFF), then `load_done`=1, `cpu_reset`=0, `overflow`=0, and further bytes are not popped.
- Gaps: bytes 12,34,56,78 with 3 to 10 idle empty cycles between them → same single write, no extra `rd` pulses.
- Overflow with `ADDR_WIDTH`=2: 16 non-sentinel bytes → writes at addr 0..3, then `load_done`=1, `overflow`=1, and a 17th byte stays in the FIFO.
- Reset mid-word: bytes AA,BB, then `reset` for one cycle, then 11,22,33,44 → single write at addr 0 with data 32'h11223344.
- `LITTLE_ENDIAN`=1: bytes 78,56,34,12 → write at addr 0 with data 32'h12345678.
